// File: rtl/sdmem_responder_if.sv
// Load/store request/response bundle between the core's memory stage and the
// data-memory responder.
interface sdmem_responder_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sdmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed access latency,
// byte/half/word lanes with sign extension and alignment/range checking.
module sdmem_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic clk,
  input  logic rst_n,
  sdmem_responder_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_next;
  logic [3:0]            cnt;
  logic                  ready;
  logic                  l_write;
  logic [1:0]            l_size;
  logic                  l_unsigned;
  logic [31:0]           l_addr;
  logic [DATA_WIDTH-1:0] l_wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic accept, fire, done;
  assign accept = (state == IDLE) && ready && bus.req_valid;
  assign fire   = (state == WAIT) && (cnt == 4'd0);
  assign done   = (state == RESP) && bus.rsp_ready;

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata;
  assign bus.rsp_err   = err;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = WAIT;
      WAIT:    if (fire)   state_next = RESP;
      RESP:    if (done)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // 33-bit subtract: the borrow flags addresses below BASE_ADDR; since the
  // base is word-aligned, diff[1:0] equals the address byte offset.
  logic [32:0]           diff;
  logic                  acc_err;
  logic [AW-1:0]         widx;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wlanes, word, shifted, load_val;

  always_comb begin
    diff     = {1'b0, l_addr} - {1'b0, BASE_ADDR};
    acc_err  = (l_size == 2'b11)
            || (l_size == 2'b01 && diff[0])
            || (l_size == 2'b10 && diff[1:0] != 2'b00)
            || diff[32]
            || ({2'b00, diff[31:2]} >= 32'(DEPTH_WORDS));
    widx     = diff[AW+1:2];
    word     = mem[widx];
    shifted  = word >> {l_addr[1:0], 3'b000};
    be       = 4'b1111;
    wlanes   = l_wdata;
    load_val = shifted;
    case (l_size)
      2'b00: begin
        be       = 4'b0001 << l_addr[1:0];
        wlanes   = {4{l_wdata[7:0]}};
        load_val = {{24{shifted[7] & ~l_unsigned}}, shifted[7:0]};
      end
      2'b01: begin
        be       = 4'b0011 << {l_addr[1], 1'b0};
        wlanes   = {2{l_wdata[15:0]}};
        load_val = {{16{shifted[15] & ~l_unsigned}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ready      <= 1'b0;
      rdata      <= '0;
      err        <= 1'b0;
      l_write    <= 1'b0;
      l_size     <= '0;
      l_unsigned <= 1'b0;
      l_addr     <= '0;
      l_wdata    <= '0;
    end else begin
      state <= state_next;
      ready <= (state_next == IDLE);
      if (accept) begin
        l_write    <= bus.req_write;
        l_size     <= bus.req_size;
        l_unsigned <= bus.req_unsigned;
        l_addr     <= bus.req_addr;
        l_wdata    <= bus.req_wdata;
        cnt        <= 4'(LATENCY - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (fire) begin
        err   <= acc_err;
        rdata <= (acc_err || l_write) ? '0 : load_val;
      end else if (done) begin
        err   <= 1'b0;
        rdata <= '0;
      end
    end
  end

  // Storage is not reset; the rst_n gate drops a store caught by reset.
  always_ff @(posedge clk) begin
    if (rst_n && fire && l_write && !acc_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_sdmem_responder.sv
// Randomised bench for sdmem_responder against a byte-addressed reference
// memory; each scenario task drives and checks its own transactions.
module tb_sdmem_responder;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam logic [31:0] BASE  = 32'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] ref_mem [logic [31:0]];

  sdmem_responder_if bus ();

  sdmem_responder #(
    .DATA_WIDTH (32),
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Byte-addressed reference: applies a store or returns the expected load.
  function automatic void model_access(input logic wr, input logic [1:0] sz, input logic uns,
                                       input logic [31:0] addr, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic er);
    int unsigned nb;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    er = (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0)
      || (longint'(addr) < longint'(BASE)) || ((longint'(addr) - longint'(BASE)) / 4 >= DEPTH);
    rd = 32'h0;
    if (er) return;
    if (wr) begin
      for (int unsigned k = 0; k < nb; k++) ref_mem[addr + k] = wd[8*k +: 8];
    end else begin
      v = 32'h0;
      for (int unsigned k = 0; k < nb; k++) v[8*k +: 8] = ref_mem[addr + k];
      if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
      rd = v;
    end
  endfunction

  task automatic do_txn(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int n = 0;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
    while (bus.req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (bus.req_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: req_ready=%b required 1", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    if (bus.rsp_valid !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_timeout: rsp_valid=%b required 1", bus.rsp_valid);
    end
    rd = bus.rsp_rdata; er = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_rdata: got %h want 0", bus.rsp_rdata); end
    n_cmp++; if (bus.rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_preload();
    logic [31:0] rd, erd, wd; logic er, eer; int lat;
    for (int unsigned a = 0; a < 256; a += 4) begin
      wd = $urandom;
      model_access(1'b1, 2'd2, 1'b0, a, wd, erd, eer);
      do_txn(1'b1, 2'd2, 1'b0, a, wd, rd, er, lat);
      n_cmp++; if (er !== eer || rd !== erd) begin n_bad++; $display("FAIL preload @%h: got err=%b rd=%h want err=%b rd=%h", a, er, rd, eer, erd); end
    end
  endtask

  task automatic test_word();
    logic [31:0] rd, erd; logic er, eer; int lat;
    model_access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, erd, eer);
    do_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL store_latency: got %0d want %0d", lat, LAT); end
    n_cmp++; if (er !== 1'b0 || rd !== 32'h0) begin n_bad++; $display("FAIL store_rsp: got err=%b rd=%h want 0/0", er, rd); end
    do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_bad++; $display("FAIL word_load: got err=%b rd=%h want 0/deadbeef", er, rd); end
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL load_latency: got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_extension();
    logic [31:0] rd, erd; logic er, eer; int lat;
    model_access(1'b1, 2'd0, 1'b0, 32'h21, 32'hABCD_1280, erd, eer);
    do_txn(1'b1, 2'd0, 1'b0, 32'h21, 32'hABCD_1280, rd, er, lat);
    do_txn(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'hFFFFFF80) begin n_bad++; $display("FAIL byte_signed: got %h want ffffff80", rd); end
    do_txn(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h00000080) begin n_bad++; $display("FAIL byte_unsigned: got %h want 00000080", rd); end
    model_access(1'b0, 2'd1, 1'b0, 32'h20, 32'h0, erd, eer);
    do_txn(1'b0, 2'd1, 1'b0, 32'h20, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== erd || rd[31:8] !== 24'hFFFF80) begin n_bad++; $display("FAIL half_signed: got %h want %h", rd, erd); end
    model_access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, erd, eer);
    do_txn(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== erd) begin n_bad++; $display("FAIL byte_lanes_kept: got %h want %h", rd, erd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic er, eer; int lat;
    logic        wr_t [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  sz_t [5] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd2};
    logic [31:0] ad_t [5] = '{32'h22, 32'h13, 32'h30, DEPTH * 4, DEPTH * 4};
    for (int i = 0; i < 5; i++) begin
      model_access(wr_t[i], sz_t[i], 1'b0, ad_t[i], 32'h5A5A_5A5A, erd, eer);
      do_txn(wr_t[i], sz_t[i], 1'b0, ad_t[i], 32'h5A5A_5A5A, rd, er, lat);
      n_cmp++; if (er !== 1'b1 || rd !== 32'h0 || eer !== 1'b1) begin n_bad++; $display("FAIL error_case%0d: got err=%b rd=%h want 1/0", i, er, rd); end
    end
    model_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, erd, eer);
    do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== erd) begin n_bad++; $display("FAIL error_readback_10: got %h want %h", rd, erd); end
    model_access(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, erd, eer);
    do_txn(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== erd) begin n_bad++; $display("FAIL error_readback_30: got %h want %h", rd, erd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, erd; logic er, eer; int lat; int n = 0;
    model_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, erd, eer);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
    while (bus.req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    // A competing store stays asserted; it must never be taken.
    bus.req_write = 1'b1; bus.req_wdata = 32'h0BAD_F00D;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    n_cmp++; if (bus.rsp_rdata !== erd || bus.rsp_err !== 1'b0) begin n_bad++; $display("FAIL bp_first: got rd=%h err=%b want %h/0", bus.rsp_rdata, bus.rsp_err, erd); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== erd || bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got v=%b rd=%h err=%b rdy=%b want 1/%h/0/0", c, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready, erd);
      end
    end
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release: got v=%b rdy=%b rd=%h err=%b want 0/1/0/0", bus.rsp_valid, bus.req_ready, bus.rsp_rdata, bus.rsp_err);
    end
    do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== erd) begin n_bad++; $display("FAIL bp_no_second_store: got %h want %h", rd, erd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; logic er, eer; int lat; int n = 0; int seen = 0;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd2;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h40; bus.req_wdata = 32'h12345678;
    while (bus.req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (bus.rsp_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b0;
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL reset_mid_rsp: got %0d response cycles want 0", seen); end
    model_access(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, erd, eer);
    do_txn(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== erd || er !== 1'b0) begin n_bad++; $display("FAIL reset_mid_readback: got %h want %h", rd, erd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, addr, wd; logic er, eer, wr, uns; logic [1:0] sz; int lat;
    for (int i = 0; i < 150; i++) begin
      wr  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      wd  = $urandom;
      case ($urandom_range(0, 9))
        0:       addr = DEPTH * 4 + $urandom_range(0, 64);
        1:       addr = 32'hFFFF_FFFC;
        default: addr = $urandom_range(0, 255);
      endcase
      if (sz != 2'd0 && $urandom_range(0, 2) != 0) addr = addr & ~32'h3 & 32'hFF | (addr & 32'hFFFF_FF00);
      model_access(wr, sz, uns, addr, wd, erd, eer);
      do_txn(wr, sz, uns, addr, wd, rd, er, lat);
      n_cmp++;
      if (rd !== erd || er !== eer || lat != LAT) begin
        n_bad++;
        $display("FAIL random%0d wr=%b sz=%0d u=%b @%h: got rd=%h err=%b lat=%0d want %h/%b/%0d", i, wr, sz, uns, addr, rd, er, lat, erd, eer, LAT);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_preload();
    test_word();
    test_extension();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
